// File: rtl/leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// leaf_out_arbiter
//
// Round-robin scheduler that shares a leaf's single BFT-bound packet channel
// between NUM_OUT_PORTS user output streams. Each accepted word is wrapped
// into a packet using a per-port destination table (leaf, port) and a
// per-port running buffer address. A per-port credit counter tracks the free
// space in the remote receive buffer and blocks a port when it reaches zero.
//
// Optional feature macro: LEAF_ARB_STATS_EN
//   When defined, per-port grant counters and an egress stall counter are
//   added as outputs. When undefined, neither the ports nor the counters
//   exist. Arbitration behaves identically in both builds.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   ap_rst_n     : asynchronous active-low reset
//   din_user     : port i payload in bits [PAYLOAD_BITS*i +: PAYLOAD_BITS]
//   vld_user     : per-port data valid
//   ack_user     : per-port accept, one-hot or zero, combinational
//   pkt_out      : {vld, leaf, port, rsv(0), addr, payload}
//   pkt_ready    : egress takes pkt_out this cycle
//   credit_vld   : credit return strobe
//   credit_port  : port index of the credit return
//   credit_cnt   : number of credits returned
//   cfg_we       : destination table write strobe
//   cfg_port     : destination table entry index
//   cfg_dest     : {leaf, port} written into the table entry
//   credit_err   : sticky flag, credit overflow or out-of-range credit index
//   grant_cnt    : (stats build) per-port 16b wrapping grant counters
//   stall_cnt    : (stats build) saturating count of back-pressured cycles
// ---------------------------------------------------------------------------
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS         = 2,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                    clk,
  input  logic                                    ap_rst_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user,
  output logic [NUM_OUT_PORTS-1:0]                ack_user,
  output logic [NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS+1:0] pkt_out,
  input  logic                                    pkt_ready,
  input  logic                                    credit_vld,
  input  logic [2:0]                              credit_port,
  input  logic [NUM_ADDR_BITS-1:0]                credit_cnt,
  input  logic                                    cfg_we,
  input  logic [2:0]                              cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
  output logic                                    credit_err
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*16-1:0]             grant_cnt,
  output logic [15:0]                             stall_cnt
`endif
);

  localparam int DEST_W     = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PKT_W      = 2 + DEST_W + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int PTR_W      = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CREDIT_MAX = 2 ** NUM_ADDR_BITS;
  localparam int CRED_W     = NUM_ADDR_BITS + 1;
  // Wide enough for a full counter plus the largest return, with one spare
  // bit so an out-of-contract credit_cnt still compares correctly.
  localparam int SUM_W      = $clog2(CREDIT_MAX + FREESPACE_UPDATE_SIZE + 1) + 1;

  // Per-port views gathered from the generate blocks for the grant mux.
  logic [PAYLOAD_BITS-1:0]  din_arr  [NUM_OUT_PORTS];
  logic [DEST_W-1:0]        dest_arr [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_arr [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] ovf;
  logic [NUM_OUT_PORTS-1:0] grant_oh;

  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic             credit_err_q, credit_err_d;

  logic             out_free;
  logic             found;
  logic             grant;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic             credit_port_bad;

  // The output register can take a new packet when empty or being drained.
  assign out_free = !pkt_q[PKT_W-1] || pkt_ready;

  // First eligible port at or after rr_q, searched cyclically.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      cand = PTR_W'((int'(rr_q) + k) % NUM_OUT_PORTS);
      if (!found && elig[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant    = found && out_free;
  assign ack_user = grant_oh;

  // ---------------------------------------------------------------------
  // Per-port state: destination table entry, address pointer, credits.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
    logic [CRED_W-1:0]        credit_q, credit_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DEST_W-1:0]        dest_q, dest_d;
    logic                     dest_vld_q, dest_vld_d;
    logic                     ret_hit;
    logic [SUM_W-1:0]         sum;
    logic                     ovf_l;

    assign din_arr[gi]  = din_user[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign dest_arr[gi] = dest_q;
    assign addr_arr[gi] = addr_q;
    assign elig[gi]     = vld_user[gi] && dest_vld_q && (credit_q != '0);
    assign grant_oh[gi] = grant && (grant_idx == PTR_W'(gi));
    assign ovf[gi]      = ovf_l;

    always_comb begin
      ret_hit    = credit_vld && (credit_port == 3'(gi));
      // Grant and return in the same cycle combine before the clamp, so a
      // return that exactly refills a just-spent credit is not an overflow.
      sum        = SUM_W'(credit_q) - SUM_W'(grant_oh[gi])
                 + (ret_hit ? SUM_W'(credit_cnt) : SUM_W'(0));
      credit_d   = CRED_W'(sum);
      ovf_l      = 1'b0;
      if (sum > SUM_W'(CREDIT_MAX)) begin
        credit_d = CRED_W'(CREDIT_MAX);
        ovf_l    = 1'b1;
      end

      // Natural wrap of the address width gives the mod-2**N sequence.
      addr_d     = addr_q + NUM_ADDR_BITS'(grant_oh[gi]);

      dest_d     = dest_q;
      dest_vld_d = dest_vld_q;
      if (cfg_we && (cfg_port == 3'(gi))) begin
        dest_d     = cfg_dest;
        dest_vld_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        credit_q   <= CRED_W'(CREDIT_MAX);
        addr_q     <= '0;
        dest_q     <= '0;
        dest_vld_q <= 1'b0;
      end else begin
        credit_q   <= credit_d;
        addr_q     <= addr_d;
        dest_q     <= dest_d;
        dest_vld_q <= dest_vld_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register, round-robin pointer, sticky error.
  // ---------------------------------------------------------------------
  assign credit_port_bad = credit_vld && ({1'b0, credit_port} >= 4'(NUM_OUT_PORTS));

  always_comb begin
    pkt_d = pkt_q;
    if (grant) begin
      pkt_d = {1'b1, dest_arr[grant_idx], 1'b0, addr_arr[grant_idx], din_arr[grant_idx]};
    end else if (pkt_ready) begin
      pkt_d = '0;
    end

    rr_d = rr_q;
    if (grant) begin
      rr_d = (int'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end

    credit_err_d = credit_err_q || (|ovf) || credit_port_bad;
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pkt_q        <= '0;
      rr_q         <= '0;
      credit_err_q <= 1'b0;
    end else begin
      pkt_q        <= pkt_d;
      rr_q         <= rr_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign pkt_out    = pkt_q;
  assign credit_err = credit_err_q;

`ifdef LEAF_ARB_STATS_EN
  // ---------------------------------------------------------------------
  // Statistics: wrapping per-port grant counts, saturating stall count.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_stat
    logic [15:0] gcnt_q, gcnt_d;

    always_comb begin
      gcnt_d = gcnt_q + 16'(grant_oh[gi]);
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        gcnt_q <= '0;
      end else begin
        gcnt_q <= gcnt_d;
      end
    end

    assign grant_cnt[gi*16 +: 16] = gcnt_q;
  end

  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (pkt_q[PKT_W-1] && !pkt_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_leaf_out_arbiter
//
// Scoreboard bench for leaf_out_arbiter with three output ports. A reference
// model, clocked on the falling edge, applies the arbitration rules to plain
// integer state (credits, addresses, table, round-robin position), checks
// ack_user and credit_err, and queues the packet each grant must produce. An
// independent monitor pops that queue whenever the egress accepts pkt_out and
// also checks that a back-pressured packet holds still.
// ---------------------------------------------------------------------------
module tb_leaf_out_arbiter;

  localparam int N     = 3;
  localparam int PKT_W = 49;

  logic              clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [N*32-1:0]   din_user = '0;
  logic [N-1:0]      vld_user = '0;
  logic [N-1:0]      ack_user;
  logic [PKT_W-1:0]  pkt_out;
  logic              pkt_ready = 1'b0;
  logic              credit_vld = 1'b0;
  logic [2:0]        credit_port = '0;
  logic [6:0]        credit_cnt = '0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_port = '0;
  logic [7:0]        cfg_dest = '0;
  logic              credit_err;
`ifdef LEAF_ARB_STATS_EN
  logic [N*16-1:0]   grant_cnt;
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  leaf_out_arbiter #(.NUM_OUT_PORTS(N)) dut (
    .clk         (clk),
    .ap_rst_n    (ap_rst_n),
    .din_user    (din_user),
    .vld_user    (vld_user),
    .ack_user    (ack_user),
    .pkt_out     (pkt_out),
    .pkt_ready   (pkt_ready),
    .credit_vld  (credit_vld),
    .credit_port (credit_port),
    .credit_cnt  (credit_cnt),
    .cfg_we      (cfg_we),
    .cfg_port    (cfg_port),
    .cfg_dest    (cfg_dest),
    .credit_err  (credit_err)
`ifdef LEAF_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int               m_credit [N];
  int               m_addr   [N];
  bit               m_tvld   [N];
  logic [7:0]       m_dest   [N];
  int               m_rr;
  bit               m_full;
  bit               m_err;
  logic [PKT_W-1:0] exp_q [$];
  int               ack_cnt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_credit[i] = 128;
      m_addr[i]   = 0;
      m_tvld[i]   = 1'b0;
      m_dest[i]   = '0;
    end
    m_rr   = 0;
    m_full = 1'b0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  // Reference model: one evaluation per cycle, mid-cycle.
  always @(negedge clk) begin : model
    logic [N-1:0] exp_ack;
    int           gp;
    int           p;
    int           c;
    if (!ap_rst_n) begin
      model_reset();
      chk("reset ack_user", 64'(ack_user), 64'd0);
      chk("reset pkt_out", 64'(pkt_out), 64'd0);
      chk("reset credit_err", 64'(credit_err), 64'd0);
    end else begin
      chk("credit_err", 64'(credit_err), 64'(m_err));
      exp_ack = '0;
      gp      = -1;
      if (!m_full || pkt_ready) begin
        for (int k = 0; k < N; k++) begin
          p = (m_rr + k) % N;
          if (gp < 0 && vld_user[p] && m_tvld[p] && m_credit[p] > 0) gp = p;
        end
      end
      if (gp >= 0) exp_ack[gp] = 1'b1;
      chk("ack_user", 64'(ack_user), 64'(exp_ack));
      for (int i = 0; i < N; i++) if (ack_user[i]) ack_cnt[i]++;

      if (gp >= 0) begin
        exp_q.push_back({1'b1, m_dest[gp], 1'b0, 7'(m_addr[gp]), din_user[gp*32 +: 32]});
        m_addr[gp]   = (m_addr[gp] + 1) % 128;
        m_credit[gp] = m_credit[gp] - 1;
        m_rr         = (gp + 1) % N;
        m_full       = 1'b1;
      end else if (pkt_ready) begin
        m_full = 1'b0;
      end

      if (credit_vld) begin
        if (int'(credit_port) >= N) begin
          m_err = 1'b1;
        end else begin
          c = m_credit[credit_port] + int'(credit_cnt);
          if (c > 128) begin
            c     = 128;
            m_err = 1'b1;
          end
          m_credit[credit_port] = c;
        end
      end

      if (cfg_we && int'(cfg_port) < N) begin
        m_dest[cfg_port] = cfg_dest;
        m_tvld[cfg_port] = 1'b1;
      end
    end
  end

  // Egress monitor: pops the scoreboard on every accepted packet.
  bit               hold_prev = 1'b0;
  logic [PKT_W-1:0] hold_pkt = '0;

  always @(negedge clk) begin : monitor
    logic [PKT_W-1:0] exp;
    if (ap_rst_n) begin
      if (hold_prev) chk("pkt_out hold", 64'(pkt_out), 64'(hold_pkt));
      if (pkt_out[PKT_W-1] && pkt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pkt_out unexpected: got %0h expected no packet at %0t", pkt_out, $time);
        end else begin
          exp = exp_q.pop_front();
          chk("pkt_out", 64'(pkt_out), 64'(exp));
        end
      end
      hold_prev = pkt_out[PKT_W-1] && !pkt_ready;
      hold_pkt  = pkt_out;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    din_user = {$urandom, $urandom, $urandom};
  endtask

  task automatic quiet();
    vld_user   = '0;
    credit_vld = 1'b0;
    cfg_we     = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    ap_rst_n = 1'b0;
    repeat (2) step();
    ap_rst_n = 1'b1;
  endtask

  task automatic cfg(input int port, input logic [7:0] dest);
    cfg_we   = 1'b1;
    cfg_port = 3'(port);
    cfg_dest = dest;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic credit(input int port, input int cnt);
    credit_vld  = 1'b1;
    credit_port = 3'(port);
    credit_cnt  = 7'(cnt);
    step();
    credit_vld  = 1'b0;
  endtask

  task automatic drain(input string name);
    quiet();
    pkt_ready = 1'b1;
    repeat (3) step();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_counts();

    // T1: two configured ports, both streaming, egress always ready.
    do_reset();
    cfg(0, 8'h35);
    cfg(1, 8'h72);
    pkt_ready = 1'b1;
    vld_user  = 3'b011;
    clear_counts();
    repeat (8) step();
    chk("T1 port0 grants", 64'(ack_cnt[0]), 64'd4);
    chk("T1 port1 grants", 64'(ack_cnt[1]), 64'd4);
    drain("T1 drain");

    // T4: grant plus unit return at full credit, then an overflowing return.
    do_reset();
    cfg(1, 8'h72);
    pkt_ready = 1'b1;
    vld_user  = 3'b010;
    credit(1, 1);
    vld_user  = '0;
    repeat (2) step();
    chk("T4 no err on net zero", 64'(credit_err), 64'd0);
    credit(1, 5);
    step();
    chk("T4 err on overflow", 64'(credit_err), 64'd1);
    clear_counts();
    vld_user = 3'b010;
    repeat (135) step();
    chk("T4 credits stayed full", 64'(ack_cnt[1]), 64'd128);
    drain("T4 drain");

    // T2: credit exhaustion, then a return of 64 and address wrap.
    do_reset();
    cfg(0, 8'h35);
    pkt_ready = 1'b1;
    vld_user  = 3'b001;
    clear_counts();
    repeat (135) step();
    chk("T2 acks until credits gone", 64'(ack_cnt[0]), 64'd128);
    clear_counts();
    credit(0, 64);
    repeat (70) step();
    chk("T2 acks after return", 64'(ack_cnt[0]), 64'd64);
    drain("T2 drain");

    // T3: five cycles of back-pressure while a packet is pending.
    do_reset();
    cfg(0, 8'h35);
    cfg(1, 8'h72);
    pkt_ready = 1'b1;
    vld_user  = 3'b011;
    repeat (3) step();
    pkt_ready = 1'b0;
    clear_counts();
    repeat (5) step();
    chk("T3 no acks while stalled", 64'(ack_cnt[0] + ack_cnt[1]), 64'd0);
    pkt_ready = 1'b1;
    repeat (4) step();
    drain("T3 drain");

    // T5: unconfigured port2 is never served until its entry is written.
    clear_counts();
    vld_user = 3'b100;
    repeat (6) step();
    chk("T5 unconfigured port idle", 64'(ack_cnt[2]), 64'd0);
    cfg(2, 8'h9A);
    repeat (4) step();
    chk("T5 served after cfg", 64'(ack_cnt[2] != 0), 64'd1);
    drain("T5 drain");

    // Randomised traffic, back-pressure, credit returns and table writes.
    do_reset();
    cfg(0, 8'h35);
    cfg(1, 8'h72);
    for (int i = 0; i < 1500; i++) begin
      vld_user    = 3'($urandom);
      pkt_ready   = ($urandom_range(0, 9) < 7);
      credit_vld  = ($urandom_range(0, 9) == 0);
      credit_port = 3'($urandom_range(0, 4));
      credit_cnt  = 7'($urandom_range(1, 64));
      cfg_we      = ($urandom_range(0, 29) == 0);
      cfg_port    = 3'($urandom_range(0, 3));
      cfg_dest    = 8'($urandom);
      step();
    end
    drain("random drain");

    // T6: asynchronous reset in the middle of a stream.
    do_reset();
    cfg(0, 8'h35);
    cfg(1, 8'h72);
    pkt_ready = 1'b1;
    vld_user  = 3'b011;
    repeat (5) step();
    chk("T6 valid before reset", 64'(pkt_out[PKT_W-1]), 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("T6 async drop of pkt_out", 64'(pkt_out[PKT_W-1]), 64'd0);
    chk("T6 no ack in reset", 64'(ack_user), 64'd0);
    repeat (2) step();
    ap_rst_n = 1'b1;
    cfg(0, 8'h35);
    cfg(1, 8'h72);
    repeat (6) step();
    drain("T6 drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
